// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture unit and its sibling generator.
package pwm_pkg;

  // Default width of the tick counter and result registers.
  localparam int PWM_CNT_W = 16;

  // Prescaler select width, shared with the generator register map.
  localparam int PWM_DIV_W = 4;

  // The prescaler must count up to 2^(2^PWM_DIV_W - 1) - 1.
  localparam int PWM_PRESC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } cap_state_e;

  // Terminal prescaler value for a given divider setting: 2^div - 1.
  function automatic logic [PWM_PRESC_W-1:0] presc_max(input logic [PWM_DIV_W-1:0] div);
    return (PWM_PRESC_W'(1) << div) - PWM_PRESC_W'(1);
  endfunction

endpackage

// File: rtl/pwm_capture_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, followed by an
// edge-detect flop. Rise and fall share the same pipeline, so both edges
// are reported with identical latency and measured widths stay exact.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Shift the raw input into the synchronizer chain; remember the last level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and rise-to-rise period of pwm_in
// in prescaled ticks and publishes each complete measurement with a
// one-cycle meas_valid strobe.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  input  logic                 en,
  input  logic [PWM_DIV_W-1:0] reg_divider,
  output logic [CNT_W-1:0]     high_cnt,
  output logic [CNT_W-1:0]     period_cnt,
  output logic                 meas_valid,
  output logic                 timeout,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic pwm_level;
  logic pwm_rise;
  logic pwm_fall;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_in),
    .level    (pwm_level),
    .rise     (pwm_rise),
    .fall     (pwm_fall)
  );

  cap_state_e             state_q, state_d;
  logic [PWM_PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_int_q, high_int_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   timeout_q, timeout_d;

  logic                   tick;
  logic                   sat;
  logic [CNT_W-1:0]       cnt_next;
  logic [PWM_PRESC_W-1:0] presc_next;

  // Prescaler tick and the counter value including this cycle's tick.
  // A tick that would overflow the counter is flagged as saturation and
  // the count is held at its maximum.
  always_comb begin
    tick       = (presc_q == presc_max(div_q));
    sat        = tick && (cnt_q == CNT_MAX);
    cnt_next   = (tick && !sat) ? cnt_q + 1'b1 : cnt_q;
    presc_next = tick ? '0 : presc_q + 1'b1;
  end

  // Next-state and datapath control. A closing edge takes priority over
  // saturation in the same cycle; en=0 overrides everything and discards
  // any in-flight measurement while keeping published results.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    high_int_d   = high_int_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        cnt_d   = '0;
        if (en) begin
          state_d = ST_WAIT_RISE;
        end
      end

      ST_WAIT_RISE: begin
        presc_d = '0;
        cnt_d   = '0;
        if (pwm_rise) begin
          div_d   = reg_divider;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        presc_d = presc_next;
        cnt_d   = cnt_next;
        if (pwm_fall) begin
          high_int_d = cnt_next;
          state_d    = ST_LOW;
        end else if (sat) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT_RISE;
        end
      end

      ST_LOW: begin
        presc_d = presc_next;
        cnt_d   = cnt_next;
        if (pwm_rise) begin
          high_cnt_d   = high_int_q;
          period_cnt_d = cnt_next;
          meas_valid_d = 1'b1;
          timeout_d    = 1'b0;
          cnt_d        = '0;
          presc_d      = '0;
          div_d        = reg_divider;
          state_d      = ST_HIGH;
        end else if (sat) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT_RISE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!en) begin
      state_d      = ST_IDLE;
      high_cnt_d   = high_cnt_q;
      period_cnt_d = period_cnt_q;
      meas_valid_d = 1'b0;
      timeout_d    = timeout_q;
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      high_int_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      high_int_q   <= high_int_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
